// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_boot_loader_pkg;

   typedef enum logic [1:0] {
      HDR,
      DATA,
      DONE,
      ERR
   } boot_state_t;

   localparam logic [31:0] BOOT_BASE_ADDR = 32'h0000_0000;
   localparam int unsigned BOOT_MAX_WORDS = 16384;

endpackage

// File: rtl/uart_boot_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
module byte_packer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o,
   output logic [1:0]  lane_o
);

   logic [1:0]  lane_q;
   logic [23:0] shreg_q;

   // The 4th byte completes the word combinationally so the
   // consumer can register it on the same edge.
   assign word_valid_o = byte_valid_i && !clr_i && (lane_q == 2'd3);
   assign word_o       = {byte_i, shreg_q};
   assign lane_o       = lane_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lane_q  <= 2'd0;
         shreg_q <= 24'd0;
      end else if (clr_i) begin
         lane_q  <= 2'd0;
         shreg_q <= 24'd0;
      end else if (byte_valid_i) begin
         lane_q <= lane_q + 2'd1;
         unique case (lane_q)
            2'd0: shreg_q[7:0]   <= byte_i;
            2'd1: shreg_q[15:8]  <= byte_i;
            2'd2: shreg_q[23:16] <= byte_i;
            2'd3: ;
         endcase
      end
   end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed image from the UART into memory port B,
// then hands port B to the CPU data path.
module uart_boot_loader
   import uart_boot_loader_pkg::*;
#(
   parameter int unsigned          ADDR_WID    = 32,
   parameter logic [ADDR_WID-1:0]  BASE_ADDR   = ADDR_WID'(BOOT_BASE_ADDR),
   parameter int unsigned          MAX_WORDS   = BOOT_MAX_WORDS,
   parameter int unsigned          TIMEOUT_CYC = 50_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rx_valid,
   input  logic [7:0]          rx_byte,
   input  logic                reload,
   input  logic [ADDR_WID-1:0] cpu_addr,
   input  logic [31:0]         cpu_wdata,
   input  logic                cpu_we,
   output logic [ADDR_WID-1:0] bus_addr,
   output logic [31:0]         bus_wdata,
   output logic                bus_we,
   output logic                cpu_run,
   output logic                load_err,
   output logic [15:0]         words_loaded
);

   boot_state_t         state_q;
   logic [14:0]         n_q;
   logic [14:0]         idx_q;
   logic [15:0]         words_q;
   logic [15:0]         words_d;
   logic [31:0]         to_q;
   logic [31:0]         to_d;
   logic                we_q;
   logic                run_q;
   logic                err_q;
   logic [ADDR_WID-1:0] addr_q;
   logic [ADDR_WID-1:0] addr_d;
   logic [31:0]         wdata_q;

   logic                loading;
   logic                accept;
   logic                clr;
   logic                word_valid;
   logic [31:0]         word;
   logic [1:0]          lane;
   logic                hdr_bad;
   logic                to_hit;

   assign loading = (state_q == HDR) || (state_q == DATA);
   assign accept  = rx_valid && loading;
   assign clr     = reload && !loading;

   byte_packer u_packer (
      .clk_i        (clk),
      .rst_ni       (rst),
      .clr_i        (clr),
      .byte_valid_i (accept),
      .byte_i       (rx_byte),
      .word_valid_o (word_valid),
      .word_o       (word),
      .lane_o       (lane)
   );

   assign hdr_bad = (word == 32'd0) || (word > MAX_WORDS);
   assign to_hit  = (to_q == TIMEOUT_CYC - 32'd1);
   assign to_d    = rx_valid ? 32'd0 : to_q + 32'd1;
   assign addr_d  = BASE_ADDR + ADDR_WID'({idx_q, 2'b00});
   assign words_d = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= HDR;
         n_q     <= '0;
         idx_q   <= '0;
         words_q <= '0;
         to_q    <= '0;
         we_q    <= 1'b0;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= 1'b0;
         unique case (state_q)
            HDR: begin
               if (lane != 2'd0 && to_hit) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
                  to_q    <= '0;
               end else begin
                  // An idle header with no partial word never times out.
                  to_q <= (lane != 2'd0) ? to_d : 32'd0;
                  if (word_valid) begin
                     if (hdr_bad) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                     end else begin
                        state_q <= DATA;
                        n_q     <= word[14:0];
                        idx_q   <= '0;
                        words_q <= '0;
                     end
                  end
               end
            end
            DATA: begin
               if (to_hit) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
                  to_q    <= '0;
               end else begin
                  to_q <= to_d;
                  if (word_valid) begin
                     we_q    <= 1'b1;
                     addr_q  <= addr_d;
                     wdata_q <= word;
                     idx_q   <= idx_q + 15'd1;
                     words_q <= words_d;
                  end
                  // idx_q already counts the write now on the bus.
                  if (we_q && idx_q == n_q) begin
                     state_q <= DONE;
                     run_q   <= 1'b1;
                     to_q    <= '0;
                  end
               end
            end
            DONE, ERR: begin
               if (reload) begin
                  state_q <= HDR;
                  run_q   <= 1'b0;
                  err_q   <= 1'b0;
                  idx_q   <= '0;
                  words_q <= '0;
                  to_q    <= '0;
               end
            end
         endcase
      end
   end

   assign bus_addr     = (state_q == DONE) ? cpu_addr  : addr_q;
   assign bus_wdata    = (state_q == DONE) ? cpu_wdata : wdata_q;
   assign bus_we       = (state_q == DONE) ? cpu_we    : we_q;
   assign cpu_run      = run_q;
   assign load_err     = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed scoreboard bench for the UART boot loader.
module tb_uart_boot_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        reload = 1'b0;
   logic [31:0] cpu_addr = 32'h0;
   logic [31:0] cpu_wdata = 32'h0;
   logic        cpu_we = 1'b0;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_we;
   logic        cpu_run;
   logic        load_err;
   logic [15:0] words_loaded;

   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;
   logic prev_we = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t exp_q[$];

   uart_boot_loader #(
      .ADDR_WID    (32),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_valid     (rx_valid),
      .rx_byte      (rx_byte),
      .reload       (reload),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_we       (cpu_we),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_we       (bus_we),
      .cpu_run      (cpu_run),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Loader writes are popped from the scoreboard as they appear.
   always @(negedge clk) begin
      if (bus_we === 1'b1 && cpu_run === 1'b0) begin
         wr_cnt++;
         chk("we_pulse", {31'd0, prev_we}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_we", bus_addr, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", bus_addr, e.a);
            chk("wr_data", bus_wdata, e.d);
         end
      end
      prev_we = (bus_we === 1'b1) && (cpu_run === 1'b0);
   end

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      logic [31:0] t;
      t = w;
      for (int i = 0; i < 4; i++) begin
         send(t[8*i +: 8]);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_run", {31'd0, cpu_run}, 32'd0);
      chk("rst_err", {31'd0, load_err}, 32'd0);
      chk("rst_we", {31'd0, bus_we}, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_words", {16'd0, words_loaded}, 32'd0);
      rst = 1'b1;
      idle(1);

      // Two-word image; CPU store attempts must not leak
      cpu_we    = 1'b1;
      cpu_addr  = 32'h1234_5678;
      cpu_wdata = 32'hDEAD_BEEF;
      exp_q.push_back('{32'h0, 32'h0000_0013});
      exp_q.push_back('{32'h4, 32'h0010_0093});
      send_word(32'h0000_0002);
      chk("pre_done_we", {31'd0, bus_we}, 32'd0);
      send_word(32'h0000_0013);
      chk("w0_we", {31'd0, bus_we}, 32'd1);
      chk("w0_addr", bus_addr, 32'h0);
      idle(1);
      chk("w0_pulse_end", {31'd0, bus_we}, 32'd0);
      send_word(32'h0010_0093);
      chk("w1_we", {31'd0, bus_we}, 32'd1);
      chk("w1_run", {31'd0, cpu_run}, 32'd0);
      idle(1);
      chk("done_run", {31'd0, cpu_run}, 32'd1);
      chk("done_words", {16'd0, words_loaded}, 32'd2);
      chk("done_q", exp_q.size(), 32'd0);
      chk("done_wrcnt", wr_cnt, 32'd2);

      // Pass-through in DONE
      cpu_addr  = 32'hFFFF_FC60;
      cpu_wdata = 32'h0000_00A5;
      cpu_we    = 1'b1;
      #1;
      chk("pt_addr", bus_addr, 32'hFFFF_FC60);
      chk("pt_wdata", bus_wdata, 32'h0000_00A5);
      chk("pt_we", {31'd0, bus_we}, 32'd1);
      cpu_we = 1'b0;
      #1;
      chk("pt_we0", {31'd0, bus_we}, 32'd0);
      cpu_we = 1'b1;

      // Zero-length header
      do_reload();
      chk("rl_run", {31'd0, cpu_run}, 32'd0);
      chk("rl_err", {31'd0, load_err}, 32'd0);
      chk("rl_words", {16'd0, words_loaded}, 32'd0);
      send_word(32'h0000_0000);
      chk("n0_err", {31'd0, load_err}, 32'd1);
      chk("n0_run", {31'd0, cpu_run}, 32'd0);
      idle(5);
      chk("n0_wrcnt", wr_cnt, 32'd2);

      // Oversize header, 16385 words
      do_reload();
      chk("rl2_err", {31'd0, load_err}, 32'd0);
      send_word(32'h0000_4001);
      chk("big_err", {31'd0, load_err}, 32'd1);
      chk("big_wrcnt", wr_cnt, 32'd2);

      // Timeout after a partial word
      do_reload();
      send_word(32'h0000_0001);
      send(8'hAA);
      send(8'hBB);
      idle(99);
      chk("to_early", {31'd0, load_err}, 32'd0);
      idle(1);
      chk("to_hit", {31'd0, load_err}, 32'd1);
      chk("to_wrcnt", wr_cnt, 32'd2);

      // Idle header waits forever, then back-to-back N=3
      do_reload();
      idle(200);
      chk("hdr_wait", {31'd0, load_err}, 32'd0);
      exp_q.push_back('{32'h0, 32'h1413_1211});
      exp_q.push_back('{32'h4, 32'h1817_1615});
      exp_q.push_back('{32'h8, 32'h1C1B_1A19});
      send_word(32'h0000_0003);
      for (int i = 0; i < 12; i++) begin
         send(8'h11 + 8'(i));
      end
      idle(1);
      chk("b2b_run", {31'd0, cpu_run}, 32'd1);
      chk("b2b_words", {16'd0, words_loaded}, 32'd3);
      chk("b2b_q", exp_q.size(), 32'd0);

      // Reset mid-DATA, then a fresh image
      cpu_we = 1'b0;
      do_reload();
      exp_q.push_back('{32'h0, 32'h0403_0201});
      send_word(32'h0000_0002);
      send_word(32'h0403_0201);
      send(8'h05);
      send(8'h06);
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("mid_rst_err", {31'd0, load_err}, 32'd0);
         chk("mid_rst_run", {31'd0, cpu_run}, 32'd0);
         chk("mid_rst_we", {31'd0, bus_we}, 32'd0);
      end
      chk("mid_rst_words", {16'd0, words_loaded}, 32'd0);
      rst = 1'b1;
      idle(1);
      exp_q.push_back('{32'h0, 32'hEFBE_ADDE});
      send_word(32'h0000_0001);
      send_word(32'hEFBE_ADDE);
      chk("fresh_addr", bus_addr, 32'h0);
      idle(1);
      chk("fresh_run", {31'd0, cpu_run}, 32'd1);
      chk("fresh_words", {16'd0, words_loaded}, 32'd1);
      chk("final_q", exp_q.size(), 32'd0);
      chk("final_wrcnt", wr_cnt, 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
